spi_byte_engine: RTL

//  Byte-level SPI mode-0 transceiver sitting directly below the SPI master command FSM.
//  Per start pulse it shifts one byte out on SPIMOSI (MSB first) while capturing one byte from SPIMISO.
//  It generates SPICLK and the active-low chip select for the serial flash (M25P16 family).
//  The FSM chains calls (0x9F RDID, then three dummy bytes) using cs_hold to keep the flash selected.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 41 ++++
 rtl/spi_byte_engine.sv | 95 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI flash byte engine.
// Holds flash opcodes, the dummy byte and the byte-engine state encoding.
package spi_pkg;

    localparam logic [7:0] SPI_RDID  = 8'h9F;
    localparam logic [7:0] SPI_RDSR  = 8'h05;
    localparam logic [7:0] SPI_READ  = 8'h03;
    localparam logic [7:0] SPI_DUMMY = 8'h00;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_SETUP    = 2'd1;
    localparam logic [1:0] ENC_SHIFT_HI = 2'd2;
    localparam logic [1:0] ENC_SHIFT_LO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ENC_IDLE,
        S_SETUP    = ENC_SETUP,
        S_SHIFT_HI = ENC_SHIFT_HI,
        S_SHIFT_LO = ENC_SHIFT_LO
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period counter producing SPICLK plus
// rise/fall strobes. Ports: clk, reset, en (transfer active), rise_tick, fall_tick, sclk.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    // A tick marks the clk edge on which SPICLK toggles.
    assign tick      = en && (cnt == LAST);
    assign rise_tick = tick && !sclk;
    assign fall_tick = tick && sclk;

    // Held cleared while idle so every transfer starts a fresh half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte transceiver: one byte out on SPIMOSI (MSB first) and one in from SPIMISO per start.
// Ports: clk, reset, start, tx_byte, cs_hold, busy, done, rx_byte, SPICLK, SPIMOSI, SPIMISO, SPISN.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       cs_hold,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       SPICLK,
    output logic       SPIMOSI,
    input  logic       SPIMISO,
    output logic       SPISN
);

    state_t     state;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic       hold_q;
    logic       rise_tick;
    logic       fall_tick;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (busy),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .sclk     (SPICLK)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            hold_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_byte <= '0;
            SPIMOSI <= 1'b0;
            SPISN   <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_byte;
                        hold_q  <= cs_hold;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        SPISN   <= 1'b0;
                        SPIMOSI <= tx_byte[7];
                        state   <= S_SETUP;
                    end
                end
                S_SETUP, S_SHIFT_LO: begin
                    if (rise_tick) begin
                        rx_sr <= {rx_sr[6:0], SPIMISO};
                        state <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (fall_tick) begin
                        if (bit_cnt == 3'd7) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rx_byte <= rx_sr;
                            SPIMOSI <= 1'b0;
                            SPISN   <= ~hold_q;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            SPIMOSI <= tx_sr[6];
                            state   <= S_SHIFT_LO;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
